// File: rtl/rpn_pkg.sv
// ============================================================================
// Module      : rpn_pkg
// Description : Shared FSM encodings and seven-segment glyphs for the RPN display.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package rpn_pkg;

    localparam int         STATE_W    = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_UPDATE  = 2'd2;

    // Active-low segments, bit6..bit0 = g..a
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_digit.sv
// ============================================================================
// Module      : seg7_digit
// Description : Combinational BCD digit to active-low seven-segment decoder.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seg7_digit
    import rpn_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : bcd_to_seg(bcd);
    end

endmodule

`default_nettype wire

// File: rtl/rpn_hex_display.sv
// ============================================================================
// Module      : rpn_hex_display
// Description : Sequential double-dabble binary-to-decimal converter driving
//               the DE1-SoC HEX displays with a load/busy/done handshake.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rpn_hex_display
    import rpn_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
)(
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    input  logic             err,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = DIGITS * 4;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;

    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [WIDTH-1:0]   mag;
    logic [CNT_W-1:0]   cnt;
    logic               sign_q;
    logic               err_q;

    logic               load_sign;
    logic [WIDTH-1:0]   load_mag;

    logic [DIGITS-1:0]  digit_blank;
    logic [6:0]         digit_seg [DIGITS];
    logic [6:0]         hex0_next;
    logic [6:0]         hex1_next;
    logic [6:0]         hex2_next;
    logic [6:0]         hex3_next;
    logic [6:0]         hex0_q;
    logic [6:0]         hex1_q;
    logic [6:0]         hex2_q;
    logic [6:0]         hex3_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (load) state_next = ST_CONVERT;
            ST_CONVERT: if (cnt == CNT_W'(WIDTH - 1)) state_next = ST_UPDATE;
            ST_UPDATE:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    // ----------------------------------------------------------- datapath
    // WIDTH-bit negation of the most negative value yields its own bit
    // pattern, which read as unsigned is exactly the wanted magnitude.
    always_comb begin
        load_sign = is_signed & value[WIDTH-1];
        load_mag  = load_sign ? ((~value) + WIDTH'(1)) : value;
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            bcd    <= '0;
            mag    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            err_q  <= 1'b0;
            done   <= 1'b0;
            hex0_q <= SEG_BLANK;
            hex1_q <= SEG_BLANK;
            hex2_q <= SEG_BLANK;
            hex3_q <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        sign_q <= load_sign;
                        err_q  <= err;
                        mag    <= load_mag;
                        bcd    <= '0;
                        cnt    <= '0;
                    end
                end
                ST_CONVERT: begin
                    bcd <= {bcd_adj[BCD_W-2:0], mag[WIDTH-1]};
                    mag <= {mag[WIDTH-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                end
                ST_UPDATE: begin
                    hex0_q <= hex0_next;
                    hex1_q <= hex1_next;
                    hex2_q <= hex2_next;
                    hex3_q <= hex3_next;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------ display
    always_comb begin
        digit_blank[0] = 1'b0;
        digit_blank[1] = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
        digit_blank[2] = (bcd[11:8] == 4'd0);
    end

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            seg7_digit u_seg (
                .bcd   (bcd[4*i +: 4]),
                .blank (digit_blank[i]),
                .seg   (digit_seg[i])
            );
        end
    endgenerate

    always_comb begin
        hex0_next = err_q ? SEG_R : digit_seg[0];
        hex1_next = err_q ? SEG_R : digit_seg[1];
        hex2_next = err_q ? SEG_E : digit_seg[2];
        hex3_next = (sign_q && !err_q) ? SEG_MINUS : SEG_BLANK;
    end

    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
    assign HEX2 = hex2_q;
    assign HEX3 = hex3_q;
    assign HEX4 = SEG_BLANK;
    assign HEX5 = SEG_BLANK;

endmodule

`default_nettype wire

// File: tb/tb_rpn_hex_display.sv
// ============================================================================
// Module      : tb_rpn_hex_display
// Description : Directed self-checking bench for rpn_hex_display.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rpn_hex_display;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] value    = 8'd0;
    logic       is_signed = 1'b0;
    logic       err      = 1'b0;
    logic       load     = 1'b0;
    logic       busy;
    logic       done;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] MN = 7'b0111111;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SR = 7'b0101111;
    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D8 = 7'b0000000;

    rpn_hex_display #(.WIDTH(8), .DIGITS(3)) dut (
        .CLOCK_50  (CLOCK_50),
        .rst_n     (rst_n),
        .value     (value),
        .is_signed (is_signed),
        .err       (err),
        .load      (load),
        .busy      (busy),
        .done      (done),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_hex(input string tag, input logic [6:0] e5, input logic [6:0] e4,
                             input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
        check(tag, {22'd0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0},
                   {22'd0, e5, e4, e3, e2, e1, e0});
    endtask

    // One load pulse; returns edges from load to done and cycles busy was seen high.
    task automatic convert(input logic [7:0] v, input logic s, input logic e,
                           output int lat, output int bcnt);
        @(negedge CLOCK_50);
        value = v; is_signed = s; err = e; load = 1'b1;
        @(posedge CLOCK_50); #1;
        load = 1'b0;
        bcnt = int'(busy);
        lat  = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge CLOCK_50); #1;
            if (done) begin
                lat = n;
                break;
            end
            bcnt += int'(busy);
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;

        // reset
        repeat (3) @(negedge CLOCK_50);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        check_hex("reset_hex", B, B, B, B, B, B);
        rst_n = 1'b1;

        // 41 unsigned
        convert(8'd41, 1'b0, 1'b0, lat, bcnt);
        check("u41_latency", 64'(lat), 64'd9);
        check("u41_busy_cycles", 64'(bcnt), 64'd9);
        check_hex("u41_hex", B, B, B, B, D4, D1);
        @(posedge CLOCK_50); #1;
        check("u41_done_one_cycle", {63'd0, done}, 64'd0);
        check("u41_idle_busy", {63'd0, busy}, 64'd0);

        // -42
        convert(8'hD6, 1'b1, 1'b0, lat, bcnt);
        check("s_m42_latency", 64'(lat), 64'd9);
        check_hex("s_m42_hex", B, B, MN, B, D4, D2);

        // -128
        convert(8'h80, 1'b1, 1'b0, lat, bcnt);
        check_hex("s_m128_hex", B, B, MN, D1, D2, D8);

        // 128 unsigned
        convert(8'h80, 1'b0, 1'b0, lat, bcnt);
        check_hex("u128_hex", B, B, B, D1, D2, D8);

        // zero
        convert(8'd0, 1'b1, 1'b0, lat, bcnt);
        check_hex("zero_hex", B, B, B, B, B, D0);

        // inner zero digit kept when hundreds present
        convert(8'd105, 1'b0, 1'b0, lat, bcnt);
        check_hex("u105_hex", B, B, B, D1, D0, D5);

        convert(8'd255, 1'b0, 1'b0, lat, bcnt);
        check_hex("u255_hex", B, B, B, D2, D5, D5);

        // error display
        convert(8'd7, 1'b0, 1'b1, lat, bcnt);
        check("err_latency", 64'(lat), 64'd9);
        check_hex("err_hex", B, B, B, SE, SR, SR);

        // load while busy is ignored
        @(negedge CLOCK_50);
        value = 8'd41; is_signed = 1'b0; err = 1'b0; load = 1'b1;
        dcnt = 0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge CLOCK_50);
            if (n == 3) begin
                check("busy_when_reload", {63'd0, busy}, 64'd1);
                value = 8'd99; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (done) dcnt++;
        end
        check("reload_done_count", 64'(dcnt), 64'd1);
        check_hex("reload_hex", B, B, B, B, D4, D1);

        // async reset mid-conversion
        @(negedge CLOCK_50);
        value = 8'd200; is_signed = 1'b0; load = 1'b1;
        @(negedge CLOCK_50);
        load = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        rst_n = 1'b0;
        #1;
        check_hex("abort_hex_blank", B, B, B, B, B, B);
        check("abort_busy_done", {62'd0, busy, done}, 64'd0);
        repeat (2) @(negedge CLOCK_50);
        rst_n = 1'b1;
        dcnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge CLOCK_50);
            if (done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        check_hex("abort_hex_held", B, B, B, B, B, B);

        convert(8'd5, 1'b0, 1'b0, lat, bcnt);
        check("after_abort_latency", 64'(lat), 64'd9);
        check_hex("after_abort_hex", B, B, B, B, B, D5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rpn_hex_display.md
Name: rpn_hex_display

Overview:
- Downstream stage of the RPN calculator core: takes the 8-bit result the core produces and drives the DE1-SoC seven-segment displays.
- Converts signed or unsigned binary to decimal with a sequential double-dabble engine, one bit per clock.
- Handshake is load/busy/done. HEX registers update atomically, so the display never shows a partial conversion.

Parameters:
- WIDTH, 8, operand width in bits; supported range 4..9; the result always fits in 3 BCD digits.
- DIGITS, 3, number of BCD digits produced; fixed at 3, not to be overridden.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset (driven from KEY[1]).
- value  input  WIDTH  operand to display; sampled only on an accepted load.
- is_signed  input  1  1 = value is two's complement; sampled with load.
- err  input  1  calculator error flag (stack under/overflow); sampled with load.
- load  input  1  single-cycle request to convert and display value.
- busy  output  1  high from the accepted load through the UPDATE state.
- done  output  1  one-cycle pulse; HEX outputs are new and valid.
- HEX0..HEX5  output  7 each  active-low segments; bit6..bit0 = g..a.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0; done=0.
  - HEX0..HEX5 = 7'b1111111 (blank).
  - Shift register and counter cleared.
  - Reset mid-conversion aborts the conversion: no done pulse, display blank.
- States: IDLE, CONVERT, UPDATE.
- IDLE:
  - load=1 at edge k: latch err and sign, where sign = is_signed & value[WIDTH-1].
  - Latch magnitude = sign ? -value : value, computed WIDTH+1 bits wide so signed -128 becomes 128.
  - Clear BCD to 0, counter to 0, go to CONVERT; busy=1 from edge k.
- CONVERT:
  - Each edge: add 3 to every BCD nibble >=5, then shift {bcd, mag} left by 1; counter++.
  - After WIDTH shifts (edge k+WIDTH), go to UPDATE.
- UPDATE, edge k+WIDTH+1:
  - Write HEX0..HEX5, assert done for exactly one cycle, return to IDLE, busy=0.
  - Total latency: load edge to valid display = WIDTH+1 edges (9 for WIDTH=8).
- load while busy=1: ignored, not queued. load at the same edge UPDATE returns to IDLE: also ignored; load is only accepted when state is already IDLE.
- Display rules, err=0:
  - HEX0 = units digit, always shown.
  - HEX1 = tens digit; blank if hundreds=0 and tens=0.
  - HEX2 = hundreds digit; blank if 0.
  - HEX3 = minus (7'b0111111) if sign, else blank.
  - HEX4 and HEX5 always blank.
- Display rules, err=1: HEX2=E (0000110), HEX1=r (0101111), HEX0=r; HEX3..HEX5 blank. Conversion still runs, so latency is unchanged.
- Digit encodings:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Between conversions, HEX holds the last written value.

Decomposition:
- rpn_pkg (shared include/package): state encoding constants, SEG_BLANK, SEG_MINUS, SEG_E, SEG_R.
- Sub-module seg7_digit: combinational 4-bit BCD to 7-bit active-low segments, with a blank input. Instantiate it 3 times.
- The FSM and double-dabble datapath stay in rpn_hex_display.

Test Plan:
- Reset, then load value=8'd41 (SW pattern 0b0000101001), is_signed=0:
  - done exactly 9 cycles after the load edge.
  - HEX2=1111111, HEX1=0011001, HEX0=1111001, HEX3..5 blank.
  - busy high for 9 cycles.
- value=8'hD6, is_signed=1 (-42): HEX3=0111111, HEX1=0011001, HEX0=0100100, HEX2 blank.
- value=8'h80, is_signed=1: displays -128. HEX3=minus, HEX2=1111001, HEX1=0100100, HEX0=0000000.
- value=8'h80, is_signed=0: displays 128, HEX3 blank.
- value=0: HEX0=1000000, all other digits blank.
- err=1 with value=7: HEX2/1/0 = E r r, HEX3 blank, done after 9 cycles.
- load=41, then load=99 pulsed 3 cycles later (busy=1): only one done; display shows 41.
- load=200 unsigned, assert rst_n=0 at cycle 4 of CONVERT:
  - All HEX blank immediately (asynchronous); busy=0, no done.
  - A fresh load of 5 after reset shows HEX0=0010010.
